mux_2to1: RTL and testbench
===========================

// Module: mux_2to1
// PURPOSE
//   2:1 data selector: y follows a when sel=0 and b when sel=1.
//   Leaf datapath primitive used wherever two sources share one sink.
//   Also drives a registered copy (y_q) with a valid flag, so clocked consumers can retime the path.
// PARAMETERS
//   WIDTH    1   bit width of a, b, y, y_q (WIDTH >= 1)
//   RST_VAL  0   value loaded into y_q on reset (WIDTH bits)
// PORTS
//   clk      in   1      single clock; all state updates on rising edge
//   rst      in   1      synchronous, active-high reset
//   a        in   WIDTH  data input 0, selected when sel=0
//   b        in   WIDTH  data input 1, selected when sel=1
//   sel      in   1      select: 0 -> a, 1 -> b
//   en       in   1      load enable for the registered path
//   y        out  WIDTH  combinational output = sel ? b : a
//   y_q      out  WIDTH  registered output
//   y_valid  out  1      high when y_q holds data loaded since reset
// BEHAVIOUR
//   - Combinational path
//     - y = sel ? b : a, bitwise over WIDTH; zero latency; independent of clk, rst and en.
//     - y must settle within the same delta or time step as any change on a, b or sel.
//     - sel = X or Z: y = X on each bit where a and b differ; y = a on bits where a == b.
//   - Registered path (rising edge of clk)
//     - rst=1: y_q <= RST_VAL, y_valid <= 0. Reset overrides en.
//     - rst=0, en=1: y_q <= (sel ? b : a), y_valid <= 1. Latency is exactly 1 cycle.
//     - rst=0, en=0: y_q and y_valid hold.
//   - Reset behaviour
//     - Reset asserted mid-stream clears y_q and y_valid on that same edge.
//     - y is unaffected by reset.
//     - The first en=1 edge after rst deasserts loads normally.
//   - No arithmetic, no width conversion; a, b, y and y_q are all exactly WIDTH bits.
//   - Before the first clock edge after power-up, y_q and y_valid are X until reset is applied.
// STRUCTURE
//   - Shared package: none required; WIDTH and RST_VAL are local parameters only.
//   - Build the combinational select as one continuous assign.
//   - Build the registered path as one always @(posedge clk) block.
//   - No sub-module.
// TESTING
//   1. WIDTH=1, a=0 b=1 sel=0 -> y=0; then sel=1 -> y=1 in the same time step (no clock needed).
//   2. WIDTH=1, a=1 b=0 sel=0 -> y=1; then sel=1 -> y=0.
//   3. rst=1 for 2 edges -> y_q=RST_VAL, y_valid=0.
//      Release rst; apply en=1, a=0, b=1, sel=1 -> after 1 edge y_q=1, y_valid=1.
//   4. en=0 with a, b and sel toggling for 3 edges -> y_q and y_valid hold; y tracks inputs every step.
//   5. WIDTH=8, a=8'hA5, b=8'h3C, en=1, sel alternating 0/1 each edge:
//      y alternates A5/3C combinationally; y_q shows the same sequence 1 cycle later.
//   6. rst=1 asserted together with en=1 mid-stream -> y_q=RST_VAL and y_valid=0 on that edge; y unaffected.

Source files
------------

// File: rtl/mux_2to1.sv
// 2:1 data selector with a combinational output and a registered, enable-gated copy.
// y_valid marks that y_q has been loaded at least once since the last reset.
module mux_2to1 #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             y_valid
);

    // Conditional operator keeps a==b bits defined when sel is unknown.
    assign y = sel ? b : a;

    // Retimed copy; reset takes priority over the load enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= RST_VAL;
            y_valid <= 1'b0;
        end else if (en) begin
            y_q     <= y;
            y_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: a 1-bit and an 8-bit instance share one clock and one reset.
module tb_mux_2to1;

    localparam int unsigned W8     = 8;
    localparam logic [7:0]  RST8   = 8'h5A;

    logic clk = 1'b0;
    logic rst;

    logic       a1, b1, s1, e1, y1, y1_q, v1;
    logic [7:0] a8, b8, y8, y8_q;
    logic       s8, e8, v8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mux_2to1 #(.WIDTH(1), .RST_VAL(1'b0)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(s1), .en(e1),
        .y(y1), .y_q(y1_q), .y_valid(v1)
    );

    mux_2to1 #(.WIDTH(W8), .RST_VAL(RST8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .sel(s8), .en(e8),
        .y(y8), .y_q(y8_q), .y_valid(v8)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp8;

    initial begin
        rst = 1'b0;
        a1 = 1'b0; b1 = 1'b0; s1 = 1'b0; e1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; s8 = 1'b0; e8 = 1'b0;
        #1;

        // Combinational select, no clock involved.
        a1 = 1'b0; b1 = 1'b1; s1 = 1'b0; #1 check("t1_sel0", 8'(y1), 8'h00);
        s1 = 1'b1;                       #1 check("t1_sel1", 8'(y1), 8'h01);
        a1 = 1'b1; b1 = 1'b0; s1 = 1'b0; #1 check("t2_sel0", 8'(y1), 8'h01);
        s1 = 1'b1;                       #1 check("t2_sel1", 8'(y1), 8'h00);

        // Two reset edges, with en high on the 8-bit side to show reset wins.
        rst = 1'b1; e1 = 1'b0; e8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        tick(); tick();
        check("t3_rst_yq1", 8'(y1_q), 8'h00);
        check("t3_rst_v1",  8'(v1),   8'h00);
        check("t3_rst_yq8", y8_q,     RST8);
        check("t3_rst_v8",  8'(v8),   8'h00);

        // First load after reset release.
        rst = 1'b0; a1 = 1'b0; b1 = 1'b1; s1 = 1'b1; e1 = 1'b1; e8 = 1'b0;
        tick();
        check("t3_load_yq1", 8'(y1_q), 8'h01);
        check("t3_load_v1",  8'(v1),   8'h01);
        check("t3_hold_yq8", y8_q,     RST8);
        check("t3_hold_v8",  8'(v8),   8'h00);

        // en low: registered path holds while y tracks the inputs (every vector selects 0).
        e1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin a1 = 1'b1; b1 = 1'b0; s1 = 1'b1; end
                1:       begin a1 = 1'b0; b1 = 1'b1; s1 = 1'b0; end
                default: begin a1 = 1'b0; b1 = 1'b0; s1 = 1'b1; end
            endcase
            #1 check($sformatf("t4_y_%0d", i), 8'(y1), 8'h00);
            tick();
            check($sformatf("t4_yq_%0d", i), 8'(y1_q), 8'h01);
            check($sformatf("t4_v_%0d", i),  8'(v1),   8'h01);
        end

        // 8-bit alternating select; y_q trails y by exactly one edge.
        a8 = 8'hA5; b8 = 8'h3C; e8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s8   = i[0];
            exp8 = i[0] ? 8'h3C : 8'hA5;
            #1 check($sformatf("t5_y_%0d", i), y8, exp8);
            tick();
            check($sformatf("t5_yq_%0d", i), y8_q, exp8);
            check($sformatf("t5_v_%0d", i),  8'(v8), 8'h01);
        end

        // Mid-stream reset together with en.
        s8 = 1'b1; rst = 1'b1; e8 = 1'b1;
        #1 check("t6_y_pre", y8, 8'h3C);
        tick();
        check("t6_yq",   y8_q,   RST8);
        check("t6_v",    8'(v8), 8'h00);
        check("t6_y",    y8,     8'h3C);
        check("t6_yq1",  8'(y1_q), 8'h00);

        // First enabled edge after release loads normally.
        rst = 1'b0; s8 = 1'b0;
        tick();
        check("t6_reload_yq", y8_q,   8'hA5);
        check("t6_reload_v",  8'(v8), 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
